kogge_stone_pipe: RTL and testbench

KOGGE_STONE_PIPE -- requirements
Module: kogge_stone_pipe

---
 rtl/kogge_stone_pkg.sv | 24 ++
 rtl/kogge_stone_pipe_cell.sv | 19 +
 rtl/kogge_stone_pipe.sv | 141 ++++++++++++++
 tb/tb_kogge_stone_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kogge_stone_pkg.sv
// Shared definitions for the Kogge-Stone pipelined adder.
// Contents:
//   pg_t  - (generate, propagate) pair carried through the prefix tree
//   clog2 - ceiling log2, sizes the prefix tree
//   lat   - accept-to-out_valid latency for a given width / pipelining choice
package kogge_stone_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int lat(input int width, input int pipe_levels);
    return (pipe_levels != 0) ? clog2(width) + 1 : 1;
  endfunction

endpackage

// File: rtl/kogge_stone_pipe_cell.sv
// Kogge-Stone prefix operator (black cell):
//   res.g = hi.g | (hi.p & lo.g)
//   res.p = hi.p & lo.p
// Ports:
//   hi  - (g,p) pair of the more significant span
//   lo  - (g,p) pair of the less significant span
//   res - combined (g,p) pair
module ks_prefix_cell
  import kogge_stone_pkg::*;
(
  input  pg_t hi,
  input  pg_t lo,
  output pg_t res
);

  assign res.g = hi.g | (hi.p & lo.g);
  assign res.p = hi.p & lo.p;

endmodule

// File: rtl/kogge_stone_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshaking.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in1, in2, cin, sub   - operands, carry-in (add only), subtract select
//   in_valid / in_ready  - input handshake (in_ready = pipeline can advance)
//   sum, cout, ovf       - result, unsigned carry-out, signed overflow
//   out_valid / out_ready- output handshake
// PIPE_LEVELS=1 registers every prefix level (latency log2(WIDTH)+1);
// PIPE_LEVELS=0 keeps the tree combinational with only the output register.
module kogge_stone_pipe
  import kogge_stone_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int PIPE_LEVELS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int LEVELS = clog2(WIDTH);
  // Side-band travelling with each operation: {in1 msb, carry-in, bitwise propagate}
  localparam int SW = WIDTH + 2;

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---- stage p0: generate / propagate from operands ----
  logic [WIDTH-1:0] b_eff;
  pg_t  [WIDTH-1:0] pg_p0;
  logic [SW-1:0]    side_p0;

  always_comb begin
    b_eff = sub ? ~in2 : in2;
    for (int i = 0; i < WIDTH; i++) begin
      pg_p0[i].g = in1[i] & b_eff[i];
      pg_p0[i].p = in1[i] ^ b_eff[i];
    end
    // Subtraction supplies its own +1 through the carry-in slot.
    side_p0 = {in1[WIDTH-1], sub | cin, in1 ^ b_eff};
  end

  // ---- prefix levels, span 1, 2, 4, ... ----
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int SPAN = 1 << l;
    pg_t  [WIDTH-1:0] pg_src, pg_nxt, pg_p;
    logic [SW-1:0]    side_src, side_p;
    logic             vld_src, vld_p;

    if (l == 0) begin : g_first
      assign pg_src   = pg_p0;
      assign side_src = side_p0;
      assign vld_src  = in_valid;
    end else begin : g_chain
      assign pg_src   = g_lvl[l-1].pg_p;
      assign side_src = g_lvl[l-1].side_p;
      assign vld_src  = g_lvl[l-1].vld_p;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= SPAN) begin : g_cell
        ks_prefix_cell u_cell (
          .hi  (pg_src[i]),
          .lo  (pg_src[i-SPAN]),
          .res (pg_nxt[i])
        );
      end else begin : g_pass
        assign pg_nxt[i] = pg_src[i];
      end
    end

    if (PIPE_LEVELS != 0) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_p <= 1'b0;
        end else if (advance) begin
          vld_p <= vld_src;
        end
      end

      always_ff @(posedge clk) begin
        if (advance) begin
          pg_p   <= pg_nxt;
          side_p <= side_src;
        end
      end
    end else begin : g_wire
      assign pg_p   = pg_nxt;
      assign side_p = side_src;
      assign vld_p  = vld_src;
    end
  end

  // ---- sum stage: carries from group (G,P) plus carry-in, XOR, output register ----
  pg_t  [WIDTH-1:0] pg_fin;
  logic [SW-1:0]    side_fin;
  logic             vld_fin;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_nxt;
  logic             ovf_nxt;

  assign pg_fin   = g_lvl[LEVELS-1].pg_p;
  assign side_fin = g_lvl[LEVELS-1].side_p;
  assign vld_fin  = g_lvl[LEVELS-1].vld_p;

  always_comb begin
    carry[0] = side_fin[WIDTH];
    for (int i = 0; i < WIDTH; i++) begin
      carry[i+1] = pg_fin[i].g | (pg_fin[i].p & side_fin[WIDTH]);
    end
    sum_nxt = side_fin[WIDTH-1:0] ^ carry[WIDTH-1:0];
    // Operand signs agree exactly when the msb propagate bit is 0.
    ovf_nxt = !side_fin[WIDTH-1] && (sum_nxt[WIDTH-1] != side_fin[WIDTH+1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (advance) begin
      out_valid <= vld_fin;
      sum       <= sum_nxt;
      cout      <= carry[WIDTH];
      ovf       <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_kogge_stone_pipe.sv
// Testbench for kogge_stone_pipe: directed checks on an 8-bit pipelined
// instance and randomized valid/ready traffic on 32-bit instances with
// PIPE_LEVELS 0 and 1, scored against an arithmetic reference model.
module tb_kogge_stone_pipe;
  import kogge_stone_pkg::*;

  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic [63:0] sum;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // 8-bit, fully pipelined
  logic       rst8, cin8, sub8, iv8, ir8, ov8, or8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;

  kogge_stone_pipe #(.WIDTH(8), .PIPE_LEVELS(1)) u_dut8 (
    .clk(clk), .rst(rst8), .in1(a8), .in2(b8), .cin(cin8), .sub(sub8),
    .in_valid(iv8), .in_ready(ir8), .sum(sum8), .cout(cout8), .ovf(ovf8),
    .out_valid(ov8), .out_ready(or8)
  );

  // 32-bit, index = PIPE_LEVELS
  logic        rst32[2], cin32[2], sub32[2], iv32[2], ir32[2];
  logic        ov32[2], or32[2], cout32[2], ovf32[2];
  logic [31:0] a32[2], b32[2], sum32[2];

  for (genvar k = 0; k < 2; k++) begin : g_dut32
    kogge_stone_pipe #(.WIDTH(32), .PIPE_LEVELS(k)) u_dut (
      .clk(clk), .rst(rst32[k]), .in1(a32[k]), .in2(b32[k]), .cin(cin32[k]),
      .sub(sub32[k]), .in_valid(iv32[k]), .in_ready(ir32[k]), .sum(sum32[k]),
      .cout(cout32[k]), .ovf(ovf32[k]), .out_valid(ov32[k]), .out_ready(or32[k])
    );
  end

  // Reference: plain unsigned arithmetic for sum/cout, signed range test for ovf.
  function automatic res_t ref_add(input int w, input longint unsigned a,
                                   input longint unsigned b, input bit c, input bit s);
    longint unsigned mask, beff, cc, full, half;
    longint sa, sb, sr;
    res_t r;
    mask = (64'd1 << w) - 64'd1;
    half = 64'd1 << (w - 1);
    beff = s ? (~b & mask) : (b & mask);
    cc   = s ? 64'd1 : {63'd0, c};
    full = (a & mask) + beff + cc;
    sa   = (a >= half) ? longint'(a) - longint'(mask) - 64'sd1 : longint'(a);
    sb   = (beff >= half) ? longint'(beff) - longint'(mask) - 64'sd1 : longint'(beff);
    sr   = sa + sb + longint'(cc);
    r.sum  = full & mask;
    r.cout = ((full >> w) & 64'd1) != 64'd0;
    r.ovf  = (sr > longint'(half) - 64'sd1) || (sr < -longint'(half));
    return r;
  endfunction

  task automatic test_reset;
    rst8 = 1'b1; iv8 = 1'b0; or8 = 1'b1; a8 = 8'h5A; b8 = 8'hA5; cin8 = 1'b1; sub8 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({ov8, sum8, cout8, ovf8} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got vld=%b sum=%h cout=%b ovf=%b want all 0", ov8, sum8, cout8, ovf8);
    end
    @(negedge clk);
    rst8 = 1'b0; or8 = 1'b0;
    #1;
    n_cmp++;
    if (ir8 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b want 1", ir8);
    end
    or8 = 1'b1;
  endtask

  task automatic test_latency;
    logic want;
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h00; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
    #1;
    n_cmp++;
    if (ir8 !== 1'b1) begin
      n_bad++;
      $display("FAIL latency_accept: in_ready got %b want 1", ir8);
    end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      iv8 = 1'b0;
      #1;
      want = (c == 4);
      n_cmp++;
      if (ov8 !== want) begin
        n_bad++;
        $display("FAIL latency_valid cycle %0d: got %b want %b", c, ov8, want);
      end
    end
    n_cmp++;
    if ({sum8, cout8, ovf8} !== {8'h01, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL latency_result: got sum=%h cout=%b ovf=%b want 01/0/0", sum8, cout8, ovf8);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ta[3], tb[3], es[3];
    logic       tc[3], ec[3];
    ta = '{8'h0A, 8'h50, 8'hFF}; tb = '{8'h03, 8'hA0, 8'h01}; tc = '{1'b0, 1'b1, 1'b0};
    es = '{8'h0D, 8'hF1, 8'h00}; ec = '{1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c < 3) begin
        a8 = ta[c]; b8 = tb[c]; cin8 = tc[c]; sub8 = 1'b0; iv8 = 1'b1;
      end else begin
        iv8 = 1'b0;
      end
      or8 = 1'b1;
      #1;
      if (c >= 4) begin
        n_cmp++;
        if ({ov8, sum8, cout8, ovf8} !== {1'b1, es[c-4], ec[c-4], 1'b0}) begin
          n_bad++;
          $display("FAIL b2b_result %0d: got vld=%b sum=%h cout=%b ovf=%b want 1/%h/%b/0",
                   c - 4, ov8, sum8, cout8, ovf8, es[c-4], ec[c-4]);
        end
      end
    end
  endtask

  task automatic test_subtract;
    logic [7:0] ta[2], tb[2], es[2];
    logic       ec[2], eo[2];
    ta = '{8'h80, 8'h05}; tb = '{8'h01, 8'h07};
    es = '{8'h7F, 8'hFE}; ec = '{1'b1, 1'b0}; eo = '{1'b1, 1'b0};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 2) begin
        a8 = ta[c]; b8 = tb[c]; cin8 = 1'b1; sub8 = 1'b1; iv8 = 1'b1;
      end else begin
        iv8 = 1'b0;
      end
      or8 = 1'b1;
      #1;
      if (c >= 4) begin
        n_cmp++;
        if ({ov8, sum8, cout8, ovf8} !== {1'b1, es[c-4], ec[c-4], eo[c-4]}) begin
          n_bad++;
          $display("FAIL sub_result %0d: got vld=%b sum=%h cout=%b ovf=%b want 1/%h/%b/%b",
                   c - 4, ov8, sum8, cout8, ovf8, es[c-4], ec[c-4], eo[c-4]);
        end
      end
    end
    sub8 = 1'b0; cin8 = 1'b0;
  endtask

  task automatic test_stall;
    res_t exp_r[4];
    res_t e;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
      if (c < 4) begin
        iv8 = 1'b1; or8 = 1'b1;
        exp_r[c] = ref_add(8, 64'(a8), 64'(b8), cin8, sub8);
      end else if (c < 7) begin
        iv8 = 1'b1; or8 = 1'b0;
      end else begin
        iv8 = 1'b0; or8 = 1'b1;
      end
      #1;
      if (c >= 4 && c < 7) begin
        n_cmp++;
        if (ir8 !== 1'b0) begin
          n_bad++;
          $display("FAIL stall_in_ready cycle %0d: got %b want 0", c, ir8);
        end
      end
      if (c >= 4) begin
        e = (c < 7) ? exp_r[0] : exp_r[c-7];
        n_cmp++;
        if ({ov8, sum8, cout8, ovf8} !== {1'b1, e.sum[7:0], e.cout, e.ovf}) begin
          n_bad++;
          $display("FAIL stall_result cycle %0d: got vld=%b sum=%h cout=%b ovf=%b want 1/%h/%b/%b",
                   c, ov8, sum8, cout8, ovf8, e.sum[7:0], e.cout, e.ovf);
        end
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (ov8 !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_no_extra: out_valid got %b want 0", ov8);
    end
  endtask

  task automatic test_reset_mid;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      rst8 = 1'b0; iv8 = 1'b0; or8 = 1'b1;
      if (c == 0) begin
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
      end else if (c < 3) begin
        a8 = 8'($urandom); b8 = 8'($urandom); iv8 = 1'b1;
      end else if (c == 4) begin
        or8 = 1'b0; rst8 = 1'b1;
      end
      #1;
      if (c == 4) begin
        n_cmp++;
        if ({ov8, sum8} !== {1'b1, 8'h30}) begin
          n_bad++;
          $display("FAIL rstmid_before: got vld=%b sum=%h want 1/30", ov8, sum8);
        end
      end else if (c == 5) begin
        n_cmp++;
        if ({ov8, sum8, cout8, ovf8, ir8} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
          n_bad++;
          $display("FAIL rstmid_after: got vld=%b sum=%h cout=%b ovf=%b rdy=%b want 0/00/0/0/1",
                   ov8, sum8, cout8, ovf8, ir8);
        end
      end else if (c > 5) begin
        n_cmp++;
        if (ov8 !== 1'b0) begin
          n_bad++;
          $display("FAIL rstmid_stale cycle %0d: out_valid got %b want 0", c, ov8);
        end
      end
    end
  endtask

  task automatic test_random(input int k);
    res_t q_exp[$];
    int   q_cyc[$];
    res_t e, got, prev;
    int   ea, lat_k;
    logic prev_stall;
    lat_k = lat(32, k);
    @(negedge clk);
    rst32[k] = 1'b1; iv32[k] = 1'b0; or32[k] = 1'b1;
    @(negedge clk);
    rst32[k] = 1'b0;
    prev_stall = 1'b0;
    prev = '0;
    for (int t = 0; t < 1000 + lat_k + 4; t++) begin
      if (t > 0) @(negedge clk);
      if (t < 1000) begin
        iv32[k]  = ($urandom_range(0, 99) < 70);
        a32[k]   = $urandom;
        b32[k]   = $urandom;
        cin32[k] = 1'($urandom);
        sub32[k] = 1'($urandom);
        or32[k]  = (t < 300) ? 1'b1 : ($urandom_range(0, 99) < 60);
      end else begin
        iv32[k] = 1'b0;
        or32[k] = 1'b1;
      end
      #1;
      got.ovf = ovf32[k]; got.cout = cout32[k]; got.sum = {32'd0, sum32[k]};
      if (prev_stall) begin
        n_cmp++;
        if (ov32[k] !== 1'b1 || got !== prev) begin
          n_bad++;
          $display("FAIL rand_hold p%0d t=%0d: got vld=%b %h want 1 %h", k, t, ov32[k], got, prev);
        end
      end
      if (ov32[k] === 1'b1 && or32[k] === 1'b1) begin
        if (q_exp.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rand_extra p%0d t=%0d: got result %h want none", k, t, got);
        end else begin
          e  = q_exp.pop_front();
          ea = q_cyc.pop_front();
          n_cmp++;
          if (got !== e) begin
            n_bad++;
            $display("FAIL rand_result p%0d t=%0d: got %h want %h", k, t, got, e);
          end
          n_cmp++;
          if ((t < 300) ? (t - ea != lat_k) : (t - ea < lat_k)) begin
            n_bad++;
            $display("FAIL rand_latency p%0d t=%0d: got %0d want %0d", k, t, t - ea, lat_k);
          end
        end
      end
      if (iv32[k] === 1'b1 && ir32[k] === 1'b1) begin
        q_exp.push_back(ref_add(32, 64'(a32[k]), 64'(b32[k]), cin32[k], sub32[k]));
        q_cyc.push_back(t);
      end
      prev_stall = (ov32[k] === 1'b1) && (or32[k] === 1'b0);
      prev = got;
    end
    n_cmp++;
    if (q_exp.size() != 0) begin
      n_bad++;
      $display("FAIL rand_drain p%0d: got %0d results outstanding want 0", k, q_exp.size());
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst32[k] = 1'b1; iv32[k] = 1'b0; or32[k] = 1'b1; cin32[k] = 1'b0;
      sub32[k] = 1'b0; a32[k] = '0; b32[k] = '0;
    end
    test_reset();
    test_latency();
    test_back_to_back();
    test_subtract();
    test_stall();
    test_reset_mid();
    test_random(0);
    test_random(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
